checker_mem_fetch: RTL
======================

Name: checker_mem_fetch

Overview:
- Read-side streaming stage for the checker's split word memory.
- Eight byte-lane RAMs form two 32-bit banks. Bank 0 holds even 32-bit words at index w>>1. Bank 1 holds odd words at index w>>1.
- The block takes burst requests on the RAMs' second port and streams 64-bit windows (word a, word a+1) to the checker core over a valid/ready interface.
- It sits downstream of the Wishbone-to-RAM write adapter, which fills the banks.

Parameters:
- WADR_W, 13, width of 32-bit word address.
- RADR_W, 12, per-bank RAM address width; must equal WADR_W-1.
- LEN_W, 8, burst length field width.

Ports:
- sys_clk  in  1  system clock.
- sys_rst_n  in  1  reset, asynchronous, active-low.
- req_valid_i  in  1  burst request valid.
- req_ready_o  out  1  request accepted when valid&ready.
- req_adr_i  in  WADR_W  start 32-bit word address (any alignment).
- req_len_i  in  LEN_W  beats minus one (0 = 1 beat, 255 = 256 beats).
- ram_adr_b0_o  out  RADR_W  bank 0 (RAMs 0-3) read address.
- ram_adr_b1_o  out  RADR_W  bank 1 (RAMs 4-7) read address.
- ram_dat_b0_i  in  32  bank 0 read data, {ram3,ram2,ram1,ram0}, 1-cycle sync read.
- ram_dat_b1_i  in  32  bank 1 read data, {ram7,ram6,ram5,ram4}.
- dat_valid_o  out  1  output beat valid.
- dat_ready_i  in  1  consumer ready.
- dat_o  out  64  {word a+1, word a}.
- dat_last_o  out  1  final beat of burst.
- busy_o  out  1  burst in progress or beats pending.

Behaviour:
- Reset values: req_ready_o=1, dat_valid_o=0, dat_last_o=0, busy_o=0, ram addresses=0, dat_o=0.
- State machine IDLE -> RUN -> DRAIN -> IDLE.
  - IDLE: req_ready_o=1. On acceptance, latch cur_adr=req_adr_i and remaining=req_len_i, then go to RUN.
  - RUN: req_ready_o=0. Issue one read per cycle while credit allows. When the beat with remaining==0 is issued, go to DRAIN.
  - DRAIN: wait until inflight==0 and buffer is empty, then go to IDLE. req_ready_o returns high in IDLE only; no back-to-back overlap.
- Issue at word address a:
  - ram_adr_b0_o=(a+1)>>1 and ram_adr_b1_o=a>>1, both driven from registers.
  - Tag the beat with a[0] and a last flag.
  - After issue: a += 2 modulo 2^WADR_W, and remaining decrements.
- Return, one cycle after issue:
  - tag 0: dat_o={b1,b0}.
  - tag 1: dat_o={b0,b1}.
- Buffering:
  - Returned beats enter a 2-entry FIFO that drives dat_*.
  - Issue is allowed iff (count + inflight - pop) < 2, where pop = dat_valid_o & dat_ready_i in the same cycle. This gives one beat per cycle under continuous ready.
- Latency: with ready held high, the first dat_valid_o rises 2 cycles after the acceptance edge. Then one beat per cycle with no bubbles.
- Backpressure:
  - dat_o and dat_last_o hold stable while valid & ~ready.
  - No beat is lost or duplicated.
  - Issue stalls at most 1 cycle after ready falls.
- busy_o = (state != IDLE).
- Address wrap: word address 8191 -> 0 (default build). A beat at a=8191 returns {word 0, word 8191}.
- Simultaneous push and pop on a full FIFO is legal; count is unchanged.
- Reset mid-burst: all state, FIFO and counters clear immediately; no further beats are emitted.

Optional Feature:
- Macro: CHECKER_FETCH_BOUND_EN.
- When defined, a request whose last word a + 2*(len+1) - 1 exceeds 2^WADR_W - 1:
  - is accepted, but no reads are issued;
  - sets sticky output err_o (1 bit, reset 0), cleared only by the next in-range accepted request;
  - returns the FSM to IDLE the following cycle.
- When undefined: err_o is absent and addresses wrap modulo 2^WADR_W as above.

Decomposition:
- Shared package checker_mem_pkg:
  - WADR_W/RADR_W constants;
  - FSM state encoding (IDLE, RUN, DRAIN);
  - beat tag struct {swap, last}.
  - The same package is usable by the write adapter.
- One sub-module: checker_fetch_fifo2, a 2-entry valid/ready FIFO with count output.
- Issue logic and FSM stay in the top module.

Test Plan:
- Aligned burst: preload word k = 0x1000_0000+k; request adr=4, len=2, ready=1 -> beats {0x10000005,0x10000004}, {…7,…6}, {…9,…8}; last on beat 3; first valid 2 cycles after accept.
- Unaligned burst: adr=7, len=1 -> {0x10000008,0x10000007}, {0x1000000A,0x10000009}; ram_adr_b0 and b1 observed as 4/3, then 5/4.
- Backpressure: adr=0, len=7, ready toggled 1010… and then held low 5 cycles -> exactly 8 ordered beats, data stable while stalled, at most 2 beats buffered.
- Wrap: adr=8190, len=1, default build -> {w8191,w8190}, {w1,w0}. With CHECKER_FETCH_BOUND_EN -> no beats, err_o=1, then a request with adr=0, len=0 clears err_o.
- Reset mid-burst: assert sys_rst_n=0 during beat 3 of a len=15 burst -> outputs at reset values asynchronously; after release, req_ready_o=1 and a new adr=2, len=0 request returns a single correct beat.
- Throughput: len=255 with ready=1 -> 256 beats in 256 consecutive cycles; busy_o deasserts 1 cycle after the last handshake.

Source files
------------

// File: rtl/checker_mem_pkg.sv
// ----------------------------------------------------------------------------
// checker_mem_pkg
// Shared definitions for the checker's split word memory: address widths,
// the fetch FSM state encoding and the per-beat tag carried alongside a read.
// Also usable by the Wishbone-to-RAM write adapter.
//
// The memory is 2^MEM_WADR_W 32-bit words. Bank 0 holds the even words and
// bank 1 holds the odd words, each at index word_address >> 1.
// ----------------------------------------------------------------------------
package checker_mem_pkg;

    localparam int MEM_WADR_W = 13;
    localparam int MEM_RADR_W = MEM_WADR_W - 1;
    localparam int MEM_LEN_W  = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } fetch_state_e;

    // swap: the beat started on an odd word, so bank 1 holds the low word.
    // last: final beat of the burst.
    typedef struct packed {
        logic swap;
        logic last;
    } beat_tag_t;

    // Assemble the 64-bit window {word a+1, word a} from the two bank outputs.
    function automatic logic [63:0] beat_window(input logic        swap,
                                                input logic [31:0] b0,
                                                input logic [31:0] b1);
        return swap ? {b0, b1} : {b1, b0};
    endfunction

endpackage

// File: rtl/checker_mem_fetch_if.sv
// ----------------------------------------------------------------------------
// checker_mem_fetch_if
// Burst request channel and 64-bit beat stream of the checker memory fetch
// stage. Signal names keep the fetch block's point of view (_i into the
// fetch block, _o out of it).
//
//   req_valid_i / req_ready_o  request handshake
//   req_adr_i                  start 32-bit word address
//   req_len_i                  beats minus one
//   dat_valid_o / dat_ready_i  beat handshake
//   dat_o                      {word a+1, word a}
//   dat_last_o                 final beat of the burst
//
// Modports: slave = fetch block, master = requester / consumer side.
// ----------------------------------------------------------------------------
interface checker_mem_fetch_if #(
    parameter int WADR_W = checker_mem_pkg::MEM_WADR_W,
    parameter int LEN_W  = checker_mem_pkg::MEM_LEN_W
);
    logic              req_valid_i;
    logic              req_ready_o;
    logic [WADR_W-1:0] req_adr_i;
    logic [LEN_W-1:0]  req_len_i;
    logic              dat_valid_o;
    logic              dat_ready_i;
    logic [63:0]       dat_o;
    logic              dat_last_o;

    modport slave (
        input  req_valid_i, req_adr_i, req_len_i, dat_ready_i,
        output req_ready_o, dat_valid_o, dat_o, dat_last_o
    );

    modport master (
        output req_valid_i, req_adr_i, req_len_i, dat_ready_i,
        input  req_ready_o, dat_valid_o, dat_o, dat_last_o
    );
endinterface

// File: rtl/checker_fetch_fifo2.sv
// ----------------------------------------------------------------------------
// checker_fetch_fifo2
// Two-entry valid/ready FIFO. The head entry drives the output directly from
// storage, so the output holds steady while the consumer stalls.
//
//   clk_i, rst_ni   clock, asynchronous active-low reset
//   push_i          write push_data_i this cycle (caller guarantees space,
//                   a push on a full FIFO is legal only together with a pop)
//   pop_ready_i     consumer ready
//   pop_valid_o     head entry valid
//   pop_data_o      head entry
//   count_o         occupancy, 0..2
// ----------------------------------------------------------------------------
module checker_fetch_fifo2 #(
    parameter int WIDTH = 65
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             push_i,
    input  logic [WIDTH-1:0] push_data_i,
    input  logic             pop_ready_i,
    output logic             pop_valid_o,
    output logic [WIDTH-1:0] pop_data_o,
    output logic [1:0]       count_o
);
    logic [WIDTH-1:0] mem_q [2];
    logic             rd_ptr_q;
    logic             wr_ptr_q;
    logic [1:0]       count_q;
    logic             do_pop;

    assign do_pop      = (count_q != 2'd0) && pop_ready_i;
    assign pop_valid_o = (count_q != 2'd0);
    assign pop_data_o  = mem_q[rd_ptr_q];
    assign count_o     = count_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            mem_q[0] <= '0;
            mem_q[1] <= '0;
            rd_ptr_q <= 1'b0;
            wr_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            // When full, wr_ptr equals rd_ptr: the slot being popped is
            // the one overwritten, so push+pop on full keeps count at 2.
            if (push_i) begin
                mem_q[wr_ptr_q] <= push_data_i;
                wr_ptr_q        <= ~wr_ptr_q;
            end
            if (do_pop) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            count_q <= count_q + 2'(push_i) - 2'(do_pop);
        end
    end

endmodule

// File: rtl/checker_mem_fetch.sv
// ----------------------------------------------------------------------------
// checker_mem_fetch
// Read-side streaming stage for the checker's split word memory. Accepts a
// burst request (start word a, len+1 beats) and streams 64-bit windows
// {word a+1, word a}, stepping a by 2 per beat, over a valid/ready stream.
//
//   sys_clk, sys_rst_n   clock, asynchronous active-low reset
//   fetch_if (slave)     request channel and beat stream
//   ram_adr_b0_o         bank 0 (even words) read address, registered
//   ram_adr_b1_o         bank 1 (odd words) read address, registered
//   ram_dat_b0_i/_b1_i   bank read data, one cycle after the address
//   busy_o               high whenever the FSM is not idle
//   err_o                (CHECKER_FETCH_BOUND_EN only) sticky out-of-range flag
//
// Build option CHECKER_FETCH_BOUND_EN: a request that would run past the top
// of memory is accepted but issues no reads and sets err_o; otherwise
// addresses wrap modulo 2^WADR_W.
// ----------------------------------------------------------------------------
module checker_mem_fetch
    import checker_mem_pkg::*;
#(
    parameter int WADR_W = MEM_WADR_W,
    parameter int RADR_W = MEM_RADR_W,
    parameter int LEN_W  = MEM_LEN_W
) (
    input  logic              sys_clk,
    input  logic              sys_rst_n,
    checker_mem_fetch_if.slave fetch_if,
    output logic [RADR_W-1:0] ram_adr_b0_o,
    output logic [RADR_W-1:0] ram_adr_b1_o,
    input  logic [31:0]       ram_dat_b0_i,
    input  logic [31:0]       ram_dat_b1_i,
    output logic              busy_o
`ifdef CHECKER_FETCH_BOUND_EN
    ,
    output logic              err_o
`endif
);
    fetch_state_e      state_q;
    logic              req_ready_q;
    logic              busy_q;
    logic [WADR_W-1:0] cur_adr_q;
    logic [WADR_W-1:0] nxt_adr_d;
    logic [LEN_W-1:0]  remaining_q;
    logic [RADR_W-1:0] adr_b0_q;
    logic [RADR_W-1:0] adr_b1_q;
    logic              inflight_q;
    beat_tag_t         tag_q;

    logic              accept;
    logic              pop;
    logic              issue;
    logic [63:0]       ret_window;
    logic              fifo_valid;
    logic [64:0]       fifo_dout;
    logic [1:0]        fifo_count;

    // Bank 0 supplies word a when a is even, word a+1 when a is odd.
    function automatic logic [RADR_W-1:0] b0_index(input logic [WADR_W-1:0] a);
        logic [WADR_W-1:0] a1;
        a1 = a + WADR_W'(1);
        return a1[WADR_W-1:1];
    endfunction

    function automatic logic [RADR_W-1:0] b1_index(input logic [WADR_W-1:0] a);
        return a[WADR_W-1:1];
    endfunction

    assign accept    = req_ready_q && fetch_if.req_valid_i;
    assign pop       = fifo_valid && fetch_if.dat_ready_i;
    assign nxt_adr_d = cur_adr_q + WADR_W'(2);

    // Credit: beats already buffered plus the one coming back from the RAM,
    // less the one leaving this cycle, must leave room for one more.
    assign issue = (state_q == ST_RUN) &&
                   ((3'(fifo_count) + 3'(inflight_q)) < (3'd2 + 3'(pop)));

`ifdef CHECKER_FETCH_BOUND_EN
    localparam int LW = WADR_W + LEN_W + 2;
    logic [LW-1:0] last_word;
    logic          out_of_range;
    logic          err_q;

    // Last word touched is a + 2*(len+1) - 1 = a + 2*len + 1.
    assign last_word    = LW'(fetch_if.req_adr_i) + (LW'(fetch_if.req_len_i) << 1) + LW'(1);
    assign out_of_range = |last_word[LW-1:WADR_W];
    assign err_o        = err_q;
`endif

    // The RAM address registers always point at the next beat to issue, so
    // the RAM reads it in the same cycle the issue decision is taken and the
    // data returns on the following cycle.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q     <= ST_IDLE;
            req_ready_q <= 1'b1;
            busy_q      <= 1'b0;
            cur_adr_q   <= '0;
            remaining_q <= '0;
            adr_b0_q    <= '0;
            adr_b1_q    <= '0;
            inflight_q  <= 1'b0;
            tag_q       <= '0;
`ifdef CHECKER_FETCH_BOUND_EN
            err_q       <= 1'b0;
`endif
        end else begin
            inflight_q <= issue;
            if (issue) begin
                tag_q <= '{swap: cur_adr_q[0], last: (remaining_q == '0)};
            end

            case (state_q)
                ST_IDLE: begin
                    if (accept) begin
                        cur_adr_q   <= fetch_if.req_adr_i;
                        remaining_q <= fetch_if.req_len_i;
                        adr_b0_q    <= b0_index(fetch_if.req_adr_i);
                        adr_b1_q    <= b1_index(fetch_if.req_adr_i);
                        req_ready_q <= 1'b0;
                        busy_q      <= 1'b1;
`ifdef CHECKER_FETCH_BOUND_EN
                        err_q       <= out_of_range;
                        // Out-of-range bursts skip RUN; DRAIN finds nothing
                        // pending and returns to IDLE on the next edge.
                        state_q     <= out_of_range ? ST_DRAIN : ST_RUN;
`else
                        state_q     <= ST_RUN;
`endif
                    end
                end
                ST_RUN: begin
                    if (issue) begin
                        cur_adr_q <= nxt_adr_d;
                        adr_b0_q  <= b0_index(nxt_adr_d);
                        adr_b1_q  <= b1_index(nxt_adr_d);
                        if (remaining_q == '0) begin
                            state_q <= ST_DRAIN;
                        end else begin
                            remaining_q <= remaining_q - LEN_W'(1);
                        end
                    end
                end
                ST_DRAIN: begin
                    if (!inflight_q && (fifo_count == 2'd0)) begin
                        state_q     <= ST_IDLE;
                        req_ready_q <= 1'b1;
                        busy_q      <= 1'b0;
                    end
                end
                default: begin
                    state_q     <= ST_IDLE;
                    req_ready_q <= 1'b1;
                    busy_q      <= 1'b0;
                end
            endcase
        end
    end

    assign ret_window = beat_window(tag_q.swap, ram_dat_b0_i, ram_dat_b1_i);

    checker_fetch_fifo2 #(
        .WIDTH(65)
    ) u_fifo (
        .clk_i       (sys_clk),
        .rst_ni      (sys_rst_n),
        .push_i      (inflight_q),
        .push_data_i ({tag_q.last, ret_window}),
        .pop_ready_i (fetch_if.dat_ready_i),
        .pop_valid_o (fifo_valid),
        .pop_data_o  (fifo_dout),
        .count_o     (fifo_count)
    );

    assign fetch_if.req_ready_o = req_ready_q;
    assign fetch_if.dat_valid_o = fifo_valid;
    assign fetch_if.dat_o       = fifo_dout[63:0];
    // Stale last bits stay in storage after a burst; only show them with valid.
    assign fetch_if.dat_last_o  = fifo_valid && fifo_dout[64];
    assign ram_adr_b0_o         = adr_b0_q;
    assign ram_adr_b1_o         = adr_b1_q;
    assign busy_o               = busy_q;

endmodule
